// File: rtl/bnn_img_loader.sv
// bnn_img_loader: packs a raster stream of binary pixels into a zero-padded image buffer
// and holds the frame until the consumer acknowledges it.
module bnn_img_loader #(
    parameter int IMG_LEN = 28,
    parameter int PAD     = 1,
    parameter int BEAT_W  = 8
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 in_valid,
    input  logic [BEAT_W-1:0]                                    in_data,
    input  logic                                                 in_last,
    output logic                                                 in_ready,
    output logic [(IMG_LEN+2*PAD)*(IMG_LEN+2*PAD)-1:0]           img_buf,
    output logic                                                 buf_valid,
    input  logic                                                 buf_ack,
    output logic                                                 err_len
);
    localparam int IMG_WIDTH = IMG_LEN + 2 * PAD;
    localparam int BUF_SIZE  = IMG_WIDTH * IMG_WIDTH;
    localparam int NPIX      = IMG_LEN * IMG_LEN;
    localparam int PW        = $clog2(NPIX + BEAT_W);
    localparam int RW        = $clog2(IMG_LEN + 1);
    localparam int IW        = $clog2(BUF_SIZE);

    typedef enum logic {LOAD, FULL} state_t;

    state_t              state;
    logic [PW-1:0]       p;
    logic [RW-1:0]       row, col;
    logic [BUF_SIZE-1:0] buf_nx;
    logic                done;
    int                  rr, cc;

    assign in_ready  = state == LOAD;
    assign buf_valid = state == FULL;
    assign done      = int'(p) + BEAT_W >= NPIX;

    // Walk the beat pixel by pixel; only interior positions are ever written,
    // so the padding border stays at its reset value of 0.
    always_comb begin
        buf_nx = img_buf;
        rr     = int'(row);
        cc     = int'(col);
        for (int i = 0; i < BEAT_W; i++) begin
            if (int'(p) + i < NPIX) begin
                buf_nx[IW'((rr + PAD) * IMG_WIDTH + cc + PAD)] = in_data[i];
                rr = (cc == IMG_LEN - 1) ? rr + 1 : rr;
                cc = (cc == IMG_LEN - 1) ? 0 : cc + 1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOAD;
            p       <= '0;
            row     <= '0;
            col     <= '0;
            img_buf <= '0;
            err_len <= 1'b0;
        end else if (state == LOAD) begin
            if (in_valid) begin
                img_buf <= buf_nx;
                if (done || in_last) begin
                    state   <= done ? FULL : LOAD;
                    err_len <= err_len | (done ^ in_last);
                    p       <= '0;
                    row     <= '0;
                    col     <= '0;
                end else begin
                    p   <= p + PW'(BEAT_W);
                    row <= RW'(rr);
                    col <= RW'(cc);
                end
            end
        end else if (buf_ack) begin
            state <= LOAD;
        end
    end
endmodule

// File: tb/tb_bnn_img_loader.sv
// tb_bnn_img_loader: directed + random frames checked against a pixel-level image model.
module tb_bnn_img_loader;
    localparam int L = 28;
    localparam int W = 30;
    localparam int B = 900;
    localparam int N = 784;

    logic         clk = 0, rst = 1, in_valid = 0, in_last = 0, buf_ack = 0;
    logic [7:0]   in_data = 0;
    logic         in_ready, buf_valid, err_len;
    logic [B-1:0] img_buf;

    logic [B-1:0] m_buf = '0;
    int           m_p = 0;
    bit           m_full = 0, m_err = 0;
    int           n_chk = 0, n_fail = 0;

    bnn_img_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .img_buf(img_buf), .buf_valid(buf_valid), .buf_ack(buf_ack),
        .err_len(err_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "/in_ready"}, 32'(in_ready), 32'(!m_full));
        chk({tag, "/buf_valid"}, 32'(buf_valid), 32'(m_full));
        chk({tag, "/err_len"}, 32'(err_len), 32'(m_err));
        n_chk++;
        assert (img_buf === m_buf) else begin
            n_fail++;
            $error("FAIL %s/img_buf: observed %0d ones expected %0d ones, %0d bits differ",
                   tag, $countones(img_buf), $countones(m_buf), $countones(img_buf ^ m_buf));
        end
    endtask

    // Model: pixel q lands at padded (q/L+1, q%L+1); beats are dropped while full.
    task automatic beat(input logic [7:0] d, input bit l);
        @(negedge clk);
        chk_all("beat");
        in_valid = 1; in_data = d; in_last = l;
        if (!m_full) begin
            for (int i = 0; i < 8; i++)
                if (m_p + i < N) m_buf[((m_p + i) / L + 1) * W + (m_p + i) % L + 1] = d[i];
            if (m_p + 8 >= N) begin
                m_full = 1; m_p = 0;
                if (!l) m_err = 1;
            end else if (l) begin
                m_err = 1; m_p = 0;
            end else m_p += 8;
        end
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        chk_all(tag);
        in_valid = 0; in_last = 0;
    endtask

    task automatic frame(input int n, input bit last, input bit ff, input string tag);
        for (int k = 0; k < n; k++) beat(ff ? 8'hFF : 8'($urandom), last && k == n - 1);
        idle(tag);
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        chk_all({tag, "/pre"});
        buf_ack = 1;
        if (m_full) begin m_full = 0; m_p = 0; end
        @(negedge clk);
        buf_ack = 0;
        chk_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1; in_valid = 0; in_last = 0;
        m_buf = '0; m_p = 0; m_full = 0; m_err = 0;
        #1 chk_all(tag);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all("reset");
        rst = 0;

        frame(98, 1, 1, "full_ff");
        chk("full_ff/ones", $countones(img_buf), 784);

        beat(8'($urandom), 1);
        beat(8'($urandom), 0);
        idle("backpressure");
        ack("ack");
        ack("ack_in_load");

        for (int k = 0; k < 98; k++) beat(k == 0 ? 8'h01 : 8'h00, k == 97);
        idle("map0");
        chk("map0/bit31", 32'(img_buf[31]), 1);
        chk("map0/ones", $countones(img_buf), 1);
        ack("map0_ack");
        for (int k = 0; k < 98; k++) beat(k == 3 ? 8'h10 : 8'h00, k == 97);
        idle("map28");
        chk("map28/bit61", 32'(img_buf[61]), 1);
        chk("map28/ones", $countones(img_buf), 1);
        ack("map28_ack");

        frame(50, 1, 0, "short");
        frame(98, 1, 0, "after_short");
        ack("after_short_ack");

        do_reset("rst_clear_err");
        frame(98, 0, 0, "no_last");
        ack("no_last_ack");

        do_reset("rst_clear");
        for (int k = 0; k < 40; k++) beat(8'($urandom), 0);
        do_reset("mid_frame_rst");
        chk("mid_frame_rst/buf_zero", $countones(img_buf), 0);
        frame(98, 1, 0, "fresh");
        ack("fresh_ack");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bnn_img_loader.md
BNN_IMG_LOADER -- requirements
Module: bnn_img_loader

Interface
REQ-001 SHALL have parameter IMG_LEN, default 28, meaning the unpadded image side length in pixels.
REQ-002 SHALL have parameter PAD, default 1, meaning the zero-padding border width on each side.
REQ-003 SHALL have parameter BEAT_W, default 8, meaning binary pixels per input beat.
REQ-004 SHALL derive IMG_WIDTH = IMG_LEN+2*PAD (30) and BUF_SIZE = IMG_WIDTH*IMG_WIDTH (900) as localparams.
REQ-005 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL provide port in_valid  input  1  an input beat is present.
REQ-008 SHALL provide port in_data  input  BEAT_W  pixels; bit 0 is the earliest pixel in raster order.
REQ-009 SHALL provide port in_last  input  1  marks the final beat of a frame.
REQ-010 SHALL provide port in_ready  output  1  the loader accepts a beat this cycle.
REQ-011 SHALL provide port img_buf  output  BUF_SIZE  padded image, bit index = row*IMG_WIDTH+col.
REQ-012 SHALL provide port buf_valid  output  1  img_buf holds a complete frame.
REQ-013 SHALL provide port buf_ack  input  1  the consumer has finished with img_buf.
REQ-014 SHALL provide port err_len  output  1  sticky frame-length error flag.

Function
REQ-015 SHALL implement two states: LOAD (in_ready=1, buf_valid=0) and FULL (in_ready=0, buf_valid=1).
REQ-016 SHALL count a beat as transferred only on a cycle with in_valid=1 and in_ready=1.
REQ-017 SHALL keep pixel counter p (0..IMG_LEN^2-1) plus row/col counters; beat bit i maps to unpadded pixel p+i at (r,c).
REQ-018 SHALL write pixel (r,c) to img_buf[(r+PAD)*IMG_WIDTH + c+PAD]; col wraps to 0 at IMG_LEN and increments row.
REQ-019 SHALL hold all padding bits (rows/cols < PAD or >= PAD+IMG_LEN) at constant 0.
REQ-020 SHALL ignore beat bits whose pixel index is >= IMG_LEN^2 (partial final beat).
REQ-021 SHALL move LOAD->FULL on the beat that writes pixel IMG_LEN^2-1; buf_valid is 1 the following cycle, a latency of 1 clock.
REQ-022 SHALL, if that completing beat has in_last=0, still enter FULL and set err_len.
REQ-023 SHALL, on a beat with in_last=1 that does not complete the frame, set err_len, reset p/row/col to 0, and remain in LOAD (short frame discarded).
REQ-024 SHALL, in FULL with buf_ack=1, return to LOAD next cycle with p/row/col=0; buf_ack in LOAD is ignored.
REQ-025 SHALL hold img_buf stable throughout FULL; interior bits retain old values in LOAD until overwritten.
REQ-026 SHALL keep in_ready combinationally equal to (state==LOAD), independent of in_valid.
REQ-027 SHALL clear err_len only by reset.

Reset
REQ-028 SHALL, on rst=1, immediately force state=LOAD, p/row/col=0, img_buf=all 0, buf_valid=0, err_len=0, in_ready=1, regardless of any in-progress frame.
REQ-029 SHALL resume accepting beats on the first rising edge after rst deasserts.

Verification
REQ-030 SHALL test a full frame: 98 beats of 8'hFF with in_last on beat 98 -> buf_valid=1 one cycle after, 784 interior bits 1, 116 border bits 0, err_len=0.
REQ-031 SHALL test bit mapping: beat 0 = 8'h01, rest 0 -> img_buf[31]=1 only; beat 3 bit 4 (pixel 28) -> img_buf[61]=1.
REQ-032 SHALL test backpressure: in_valid during FULL -> in_ready=0 and img_buf unchanged; buf_ack pulse -> in_ready=1 next cycle.
REQ-033 SHALL test a short frame: in_last on beat 50 -> err_len=1, buf_valid stays 0; next 98-beat frame completes normally.
REQ-034 SHALL test a missing last: 98 beats, in_last=0 -> buf_valid=1 and err_len=1.
REQ-035 SHALL test mid-frame reset: rst after beat 40 -> img_buf=0, p=0; a fresh 98-beat frame loads correctly.
